// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the multi-region OBI-to-Wishbone bridge.
package obi_wb_pkg;

  localparam int MAX_REGIONS  = 16;
  localparam int REGION_IDX_W = $clog2(MAX_REGIONS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Why a transaction ended; anything but ERR_NONE raises obi_err_o.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNMAPPED = 2'd1;
  localparam logic [1:0] ERR_SLAVE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic logic [63:0] wb_translate(input logic [63:0] base,
                                               input logic [63:0] addr,
                                               input int          offset_w);
    logic [63:0] mask;
    mask = (64'd1 << offset_w) - 64'd1;
    return base | (addr & mask);
  endfunction

endpackage

// File: rtl/obi_wb_region_dec.sv
// Region decoder: matches the upper address byte against the region table.
module obi_wb_region_dec
  import obi_wb_pkg::*;
#(
  parameter int                       NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*8-1:0] REGION_ID   = {8'hE, 8'hF, 8'h0, 8'h0}
) (
  input  logic [7:0]              id_i,
  output logic                    hit_o,
  output logic [REGION_IDX_W-1:0] idx_o
);

  // Region 0 occupies the most significant byte; scanning downward leaves
  // the lowest matching index in place.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (id_i == REGION_ID[(NUM_REGIONS-1-i)*8 +: 8]) begin
        hit_o = 1'b1;
        idx_o = REGION_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/obi_wb_bridge_mr.sv
// Multi-region OBI-to-Wishbone classic bridge, one outstanding transaction.
// Optional bus watchdog enabled by defining OBI_WB_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a request, grant follows obi_req_i
// BUS     | Wishbone cycle in progress, waiting for ack/err (or timeout)
// RESP    | one-cycle OBI response with latched data and error
module obi_wb_bridge_mr
  import obi_wb_pkg::*;
#(
  parameter int                            ADDR_W         = 32,
  parameter int                            DATA_W         = 32,
  parameter int                            NUM_REGIONS    = 4,
  parameter int                            OFFSET_W       = 8,
  parameter logic [NUM_REGIONS*8-1:0]      REGION_ID      = {8'hE, 8'hF, 8'h0, 8'h0},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_WB_BASE = {32'h4300, 32'h2300, 32'h0, 32'h0},
  parameter int                            TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                obi_req_i,
  output logic                obi_gnt_o,
  input  logic [ADDR_W-1:0]   obi_addr_i,
  input  logic                obi_wr_en_i,
  input  logic [DATA_W/8-1:0] obi_byte_en_i,
  input  logic [DATA_W-1:0]   obi_wdata_i,
  output logic                obi_rvalid_o,
  output logic [DATA_W-1:0]   obi_rdata_o,
  output logic                obi_err_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_wdata_o,
  output logic                wb_wr_en_o,
  output logic [DATA_W/8-1:0] wb_byte_en_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic [DATA_W-1:0]   wb_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("obi_wb_bridge_mr: NUM_REGIONS or TIMEOUT_CYCLES out of range");
  end

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic                    we_q, we_d;
  logic [1:0]              err_q, err_d;
  logic                    hit;
  logic [REGION_IDX_W-1:0] region_idx;
  logic [ADDR_W-1:0]       region_base;

  obi_wb_region_dec #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_ID   (REGION_ID)
  ) u_region_dec (
    .id_i  (obi_addr_i[ADDR_W-1 -: 8]),
    .hit_o (hit),
    .idx_o (region_idx)
  );

  always_comb begin
    region_base = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region_idx == REGION_IDX_W'(i)) begin
        region_base = REGION_WB_BASE[(NUM_REGIONS-1-i)*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        if (obi_req_i) begin
          addr_d  = ADDR_W'(wb_translate(64'(region_base), 64'(obi_addr_i), OFFSET_W));
          wdata_d = obi_wdata_i;
          be_d    = obi_byte_en_i;
          we_d    = obi_wr_en_i;
          rdata_d = '0;
          if (hit) begin
            err_d   = ERR_NONE;
            state_d = ST_BUS;
          end else begin
            err_d   = ERR_UNMAPPED;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUS: begin
        // Slave error takes priority over a simultaneous ack.
        if (wb_err_i) begin
          err_d   = ERR_SLAVE;
          rdata_d = '0;
          state_d = ST_RESP;
        end else if (wb_ack_i) begin
          err_d   = ERR_NONE;
          rdata_d = we_q ? '0 : wb_rdata_i;
          state_d = ST_RESP;
        end
`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      err_q     <= ERR_NONE;
`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      err_q     <= err_d;
`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign obi_gnt_o    = rst_ni && (state_q == ST_IDLE) && obi_req_i;
  assign obi_rvalid_o = (state_q == ST_RESP);
  assign obi_err_o    = (state_q == ST_RESP) && (err_q != ERR_NONE);
  assign obi_rdata_o  = rdata_q;
  assign wb_cyc_o     = (state_q == ST_BUS);
  assign wb_stb_o     = (state_q == ST_BUS);
  assign wb_addr_o    = addr_q;
  assign wb_wdata_o   = wdata_q;
  assign wb_wr_en_o   = we_q;
  assign wb_byte_en_o = be_q;

endmodule

// File: doc/obi_wb_bridge_mr.md
# obi_wb_bridge_mr

Multi-region OBI-to-Wishbone bridge: accepts single OBI transactions from the core, decodes the upper address byte against a parametrised table of regions, and translates each hit to a Wishbone classic-cycle transfer. Unmapped accesses and stalled slaves terminate with an OBI error response instead of hanging the core. Sits between the SoC data bus and the Smartwave peripheral Wishbone interconnect, replacing the fixed two-target bridge.

## Interface
- ADDR_W, 32, address width (OBI and WB)
- DATA_W, 32, data width; multiple of 8
- NUM_REGIONS, 4, number of decoded regions (1..16)
- OFFSET_W, 8, low address bits passed through untranslated
- REGION_ID, {8'hE,8'hF,8'h0,8'h0}, packed NUM_REGIONS×8; compared with obi_addr_i[ADDR_W-1:ADDR_W-8]
- REGION_WB_BASE, {32'h4300,32'h2300,0,0}, packed NUM_REGIONS×ADDR_W; WB base per region
- TIMEOUT_CYCLES, 255, max cycles waiting for wb_ack_i/wb_err_i

Ports (reset rst_ni, asynchronous, active-low; clock clk_i):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant
- obi_addr_i  in  ADDR_W  OBI address
- obi_wr_en_i  in  1  1 = write
- obi_byte_en_i  in  DATA_W/8  byte enables
- obi_wdata_i  in  DATA_W  write data
- obi_rvalid_o  out  1  response valid
- obi_rdata_o  out  DATA_W  read data
- obi_err_o  out  1  error qualifier, valid with obi_rvalid_o
- wb_addr_o  out  ADDR_W  translated address
- wb_wdata_o  out  DATA_W  write data
- wb_wr_en_o  out  1  write enable
- wb_byte_en_o  out  DATA_W/8  byte select
- wb_cyc_o, wb_stb_o  out  1 each  cycle/strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  slave error
- wb_rdata_i  in  DATA_W  read data

## Operation
- States: IDLE, BUS, RESP.
- IDLE: obi_gnt_o = obi_req_i (combinational). On req: register wr_en, byte_en, wdata, hit, translated address; hit → BUS, miss → RESP with err=1.
- Decode: lowest-index region whose REGION_ID matches wins. wb_addr_o = REGION_WB_BASE[i] | zero-extended obi_addr_i[OFFSET_W-1:0].
- BUS: wb_cyc_o = wb_stb_o = 1. wb_ack_i → capture wb_rdata_i (reads only; writes return 0), err=0, → RESP. wb_err_i → err=1, rdata 0, → RESP. Both same cycle: err wins.
- RESP: obi_rvalid_o = 1 for exactly one cycle, obi_err_o = latched err; → IDLE. No grant in BUS or RESP; one outstanding transaction.
- Miss: no WB cycle; obi_rdata_o = 0.
- Reset (any state, incl. mid-BUS): all outputs 0, state IDLE, cyc/stb drop asynchronously; in-flight transaction abandoned, no response.

## Timing
- Hit: req/gnt cycle T; cyc/stb from T+1; ack at cycle A → rvalid at A+1. Zero-wait slave: rvalid at T+2.
- Miss: rvalid+err at T+1.
- wb_* address/data/sel/we stable from T+1 until cyc deasserts.
- Back-to-back: next grant earliest in cycle after RESP (hit throughput 1 per 3 cycles).

## Configuration
- OBI_WB_BRIDGE_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYCLES+1) cleared on entering BUS, increments each BUS cycle without ack/err; on reaching TIMEOUT_CYCLES deassert cyc/stb, → RESP with err=1, rdata 0. Ack in the same cycle as timeout wins (normal response).
- Undefined: no counter; BUS waits indefinitely.

## Structure
- Package obi_wb_pkg: state enum, MAX_REGIONS = 16, error-code localparams, function for address translation.
- Sub-module obi_wb_region_dec: combinational decoder, outputs hit and region index.

## Test plan
- Read region 0 (addr 0x0E00_0004), slave acks 2 cycles after stb, rdata 0xDEAD_BEEF → wb_addr_o 0x0000_4304, rvalid at T+4, rdata 0xDEAD_BEEF, err 0.
- Write region 1 (0x0F00_0010, wdata 0x1234_5678, be 4'b0011) → wb_addr 0x0000_2310, we=1, sel 0011, rvalid 1 cycle after ack, rdata 0.
- Unmapped 0x1000_0000 → gnt at T, rvalid+err at T+1, wb_cyc_o never asserted.
- wb_err_i on read → rvalid, err 1, rdata 0; simultaneous ack+err → err 1.
- With OBI_WB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack → cyc drops after 8 BUS cycles, rvalid+err next cycle; then normal read succeeds.
- rst_ni low while in BUS → cyc/stb 0 immediately, no rvalid after release; next request completes normally.
